retire_unit: RTL and testbench

- In-order retirement buffer that drives the architectural register file write port (regwr/rd/data).
- Dispatch allocates entries in program order. Execution units return results out of order, tagged with the entry index.
- Results are retired strictly in allocation order, at most one per cycle.
- Sits between the execute/complete stage and the register file.

---
 rtl/retire_unit.sv | 126 ++++++++++++
 tb/tb_retire_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_unit.sv
// In-order retirement buffer feeding the register file write port.
// Optional macro RETIRE_BYPASS_EN: a head entry completing this cycle retires at the same edge.
module retire_unit #(
  parameter int DEPTH     = 8,
  parameter int TAG_B     = 3,
  parameter int DATA_SIZE = 64,
  parameter int REG_B     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_valid,
  input  logic                 alloc_regwr,
  input  logic [REG_B-1:0]     alloc_rd,
  output logic                 alloc_ready,
  output logic [TAG_B-1:0]     alloc_tag,
  input  logic                 cmpl_valid,
  input  logic [TAG_B-1:0]     cmpl_tag,
  input  logic [DATA_SIZE-1:0] cmpl_data,
  input  logic                 flush,
  output logic                 regwr,
  output logic [REG_B-1:0]     rd,
  output logic [DATA_SIZE-1:0] data,
  output logic                 empty,
  output logic [TAG_B:0]       count
);

  localparam logic [TAG_B:0] LP_FULL = (TAG_B+1)'(DEPTH);

  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_done;
  logic [DEPTH-1:0]     r_ent_regwr;
  logic [REG_B-1:0]     r_ent_rd   [DEPTH];
  logic [DATA_SIZE-1:0] r_ent_data [DEPTH];
  logic [TAG_B-1:0]     r_head;
  logic [TAG_B-1:0]     r_tail;
  logic [TAG_B:0]       r_count;
  logic                 r_regwr;
  logic [REG_B-1:0]     r_rd;
  logic [DATA_SIZE-1:0] r_data;

  logic                 w_alloc;
  logic                 w_cmpl_hit;
  logic                 w_bypass;
  logic                 w_retire;
  logic                 w_ret_wr;
  logic [DATA_SIZE-1:0] w_ret_data;

  assign alloc_ready = (r_count < LP_FULL);
  assign alloc_tag   = r_tail;
  assign w_alloc     = alloc_valid && alloc_ready;
  assign w_cmpl_hit  = cmpl_valid && r_valid[cmpl_tag];

`ifdef RETIRE_BYPASS_EN
  assign w_bypass = cmpl_valid && (cmpl_tag == r_head) && r_valid[r_head] && !r_done[r_head];
`else
  assign w_bypass = 1'b0;
`endif

  // Retire decision uses registered done bits; bypass is the only same-edge path.
  assign w_retire   = r_valid[r_head] && (r_done[r_head] || w_bypass);
  assign w_ret_wr   = r_ent_regwr[r_head] && (r_ent_rd[r_head] != '0);
  assign w_ret_data = w_bypass ? cmpl_data : r_ent_data[r_head];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_regwr <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_regwr <= 1'b0;
    end else begin
      if (w_cmpl_hit) begin
        r_done[cmpl_tag] <= 1'b1;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
        r_regwr         <= w_ret_wr;
        r_rd            <= r_ent_rd[r_head];
        r_data          <= w_ret_data;
      end else begin
        r_regwr <= 1'b0;
      end
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (w_alloc) begin
        r_ent_regwr[r_tail] <= alloc_regwr;
        r_ent_rd[r_tail]    <= alloc_rd;
      end
      if (w_cmpl_hit) begin
        r_ent_data[cmpl_tag] <= cmpl_data;
      end
    end
  end

  assign regwr = r_regwr;
  assign rd    = r_rd;
  assign data  = r_data;
  assign count = r_count;
  assign empty = (r_count == '0);

endmodule

// File: tb/tb_retire_unit.sv
// Randomized bench for retire_unit against a program-order queue model.
module tb_retire_unit;
  localparam int DEPTH     = 8;
  localparam int TAG_B     = 3;
  localparam int DATA_SIZE = 64;
  localparam int REG_B     = 5;

`ifdef RETIRE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 alloc_valid = 1'b0;
  logic                 alloc_regwr = 1'b0;
  logic [REG_B-1:0]     alloc_rd = '0;
  logic                 alloc_ready;
  logic [TAG_B-1:0]     alloc_tag;
  logic                 cmpl_valid = 1'b0;
  logic [TAG_B-1:0]     cmpl_tag = '0;
  logic [DATA_SIZE-1:0] cmpl_data = '0;
  logic                 flush = 1'b0;
  logic                 regwr;
  logic [REG_B-1:0]     rd;
  logic [DATA_SIZE-1:0] data;
  logic                 empty;
  logic [TAG_B:0]       count;

  retire_unit #(.DEPTH(DEPTH), .TAG_B(TAG_B), .DATA_SIZE(DATA_SIZE), .REG_B(REG_B)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_regwr(alloc_regwr), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
    .flush(flush), .regwr(regwr), .rd(rd), .data(data),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   tag;
    logic                 wr;
    logic [REG_B-1:0]     rd;
    bit                   done;
    logic [DATA_SIZE-1:0] d;
  } ent_t;

  ent_t                         inflight[$];
  int                           next_tag = 0;
  logic                         m_regwr = 1'b0;
  logic [REG_B-1:0]             m_rd = '0;
  logic [DATA_SIZE-1:0]         m_data = '0;
  logic [REG_B+DATA_SIZE-1:0]   exp_q[$];
  logic [REG_B+DATA_SIZE-1:0]   wlog[$];
  int                           checks = 0;
  int                           errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    exp_q.delete();
    next_tag = 0;
    m_regwr  = 1'b0;
    m_rd     = '0;
    m_data   = '0;
  endtask

  task automatic drive(input bit av, input bit aw, input int ard, input bit cv,
                       input int ctag, input logic [DATA_SIZE-1:0] cd, input bit fl);
    alloc_valid = av;
    alloc_regwr = aw;
    alloc_rd    = REG_B'(ard);
    cmpl_valid  = cv;
    cmpl_tag    = TAG_B'(ctag);
    cmpl_data   = cd;
    flush       = fl;
  endtask

  // Called just after a falling edge with inputs driven; returns after the next falling edge.
  task automatic step();
    bit   full;
    bit   did_ret;
    ent_t e;
    #1;
    chk("alloc_ready", alloc_ready, inflight.size() < DEPTH);
    chk("alloc_tag", alloc_tag, next_tag);
    if (flush) begin
      inflight.delete();
      next_tag = 0;
      m_regwr  = 1'b0;
    end else begin
      full    = (inflight.size() >= DEPTH);
      did_ret = 1'b0;
      if (inflight.size() > 0) begin
        if (inflight[0].done) begin
          did_ret = 1'b1;
          m_data  = inflight[0].d;
        end else if (BYPASS && cmpl_valid && (int'(cmpl_tag) == inflight[0].tag)) begin
          did_ret = 1'b1;
          m_data  = cmpl_data;
        end
      end
      if (did_ret) begin
        m_regwr = inflight[0].wr && (inflight[0].rd != 0);
        m_rd    = inflight[0].rd;
        void'(inflight.pop_front());
      end else begin
        m_regwr = 1'b0;
      end
      if (cmpl_valid) begin
        foreach (inflight[k]) begin
          if (inflight[k].tag == int'(cmpl_tag)) begin
            inflight[k].done = 1'b1;
            inflight[k].d    = cmpl_data;
          end
        end
      end
      if (alloc_valid && !full) begin
        e.tag = next_tag; e.wr = alloc_regwr; e.rd = alloc_rd; e.done = 1'b0; e.d = '0;
        inflight.push_back(e);
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
    if (m_regwr) exp_q.push_back({m_rd, m_data});
    @(posedge clk);
    #1;
    chk("regwr", regwr, m_regwr);
    chk("rd", rd, m_rd);
    chk("data", data, m_data);
    chk("count", count, inflight.size());
    chk("empty", empty, inflight.size() == 0);
    if (regwr) begin
      wlog.push_back({rd, data});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h required=none", {rd, data});
      end else begin
        chk("write_order", {rd, data}, exp_q.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, '0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int t;
    // Reset state
    #12;
    chk("rst_regwr", regwr, 0);
    chk("rst_rd", rd, 0);
    chk("rst_data", data, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Out-of-order completion, in-order writes
    wlog.delete();
    drive(1, 1, 5, 0, 0, '0, 0); step();
    drive(1, 1, 6, 0, 0, '0, 0); step();
    drive(1, 1, 7, 0, 0, '0, 0); step();
    drive(0, 0, 0, 1, 2, 64'hC, 0); step();
    drive(0, 0, 0, 1, 0, 64'hA, 0); step();
    drive(0, 0, 0, 1, 1, 64'hB, 0); step();
    idle(4);
    chk("ooo_nwrites", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("ooo_w0", wlog[0], {5'd5, 64'hA});
      chk("ooo_w1", wlog[1], {5'd6, 64'hB});
      chk("ooo_w2", wlog[2], {5'd7, 64'hC});
    end
    chk("ooo_count", count, 0);

    // Fill, refuse 9th, wrap
    drive(0, 0, 0, 0, 0, '0, 1); step();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, i + 1, 0, 0, '0, 0); step();
    end
    drive(0, 0, 0, 0, 0, '0, 0); #1;
    chk("full_ready", alloc_ready, 0);
    chk("full_count", count, 8);
    drive(1, 1, 20, 0, 0, '0, 0); step();
    chk("full_9th_count", count, 8);
    drive(0, 0, 0, 1, 0, 64'h100, 0); step();
    idle(1);
    drive(1, 1, 21, 0, 0, '0, 0); #1;
    chk("wrap_ready", alloc_ready, 1);
    chk("wrap_tag", alloc_tag, 0);
    step();

    // Non-writing entries
    drive(0, 0, 0, 0, 0, '0, 1); step();
    drive(1, 1, 0, 0, 0, '0, 0); step();
    drive(1, 0, 9, 0, 0, '0, 0); step();
    drive(1, 1, 3, 0, 0, '0, 0); step();
    wlog.delete();
    drive(0, 0, 0, 1, 0, 64'hFF, 0); step();
    drive(0, 0, 0, 1, 1, 64'hFF, 0); step();
    drive(0, 0, 0, 1, 2, 64'h33, 0); step();
    idle(3);
    chk("nowr_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) chk("nowr_w0", wlog[0], {5'd3, 64'h33});
    chk("nowr_count", count, 0);

    // Flush priority
    drive(0, 0, 0, 0, 0, '0, 1); step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 10 + i, 0, 0, '0, 0); step();
    end
    drive(0, 0, 0, 1, 2, 64'h22, 0); step();
    drive(0, 0, 0, 1, 3, 64'h33, 0); step();
    wlog.delete();
    drive(1, 1, 20, 1, 0, 64'h99, 1); step();
    idle(3);
    chk("flush_nwrites", wlog.size(), 0);
    chk("flush_count", count, 0);
    drive(1, 1, 1, 0, 0, '0, 0); #1;
    chk("flush_tag", alloc_tag, 0);
    step();

    // Completion-to-write latency at head
    drive(0, 0, 0, 0, 0, '0, 1); step();
    drive(1, 1, 4, 0, 0, '0, 0); step();
    drive(0, 0, 0, 1, 0, 64'h44, 0); step();
    chk("lat_edge_n", regwr, BYPASS ? 1 : 0);
    idle(1);
    chk("lat_edge_n1", regwr, BYPASS ? 0 : 1);

    // Random traffic with a mid-stream asynchronous reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        drive(0, 0, 0, 0, 0, '0, 0);
        #2 reset = 1'b0;
        #1;
        chk("arst_regwr", regwr, 0);
        chk("arst_rd", rd, 0);
        chk("arst_data", data, 0);
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_ready", alloc_ready, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
      end
      if (inflight.size() > 0 && $urandom_range(0, 3) != 0)
        t = inflight[$urandom_range(0, inflight.size() - 1)].tag;
      else
        t = $urandom_range(0, DEPTH - 1);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 31),
            $urandom_range(0, 2) != 0, t, {$urandom, $urandom}, $urandom_range(0, 60) == 0);
      step();
    end

    // Drain
    while (inflight.size() > 0) begin
      t = inflight[inflight.size() - 1].tag;
      drive(0, 0, 0, 1, t, {$urandom, $urandom}, 0);
      step();
      for (int k = 0; k < inflight.size(); k++) begin
        if (!inflight[k].done) begin
          drive(0, 0, 0, 1, inflight[k].tag, {$urandom, $urandom}, 0);
          step();
          break;
        end
      end
      idle(1);
    end
    idle(2);
    chk("drain_exp_q", exp_q.size(), 0);
    chk("drain_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
